// File: rtl/i2c_target.sv
// ---------------------------------------------------------------------------
// i2c_target -- I2C target (slave) exposing an 8-bit register pointer and a
// one-cycle read/write strobe interface to the surrounding fabric.
//
// Ports:
//   CK         single clock, all logic on the rising edge
//   SR         synchronous active-high reset
//   SCL_I      bus clock from the pad buffer output
//   SDA_I      bus data from the pad buffer output
//   SDA_OE     1 = pull SDA low (pad input tied 0), 0 = release
//   REG_ADDR   register pointer presented to the fabric
//   REG_WDATA  write data, valid while REG_WE = 1
//   REG_WE     one-CK write strobe
//   REG_RE     one-CK read strobe
//   REG_RDATA  read data from the fabric, captured the CK after REG_RE
//   BUSY       high from START to STOP, addressed or not
// ---------------------------------------------------------------------------
module i2c_target #(
  parameter logic [6:0] DEV_ADDR    = 7'h42,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       CK,
  input  logic       SR,
  input  logic       SCL_I,
  input  logic       SDA_I,
  output logic       SDA_OE,
  output logic [7:0] REG_ADDR,
  output logic [7:0] REG_WDATA,
  output logic       REG_WE,
  output logic       REG_RE,
  input  logic [7:0] REG_RDATA,
  output logic       BUSY
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, WDATA, WACK, RDATA, RACK, IGNORE
  } state_t;

  // Bus input synchronizers plus one extra flop each for edge detection.
  logic [SYNC_STAGES-1:0] scl_sync_reg, sda_sync_reg;
  logic                   scl_prev_reg, sda_prev_reg;
  logic                   scl_s, sda_s;
  logic                   scl_rise, scl_fall, start_det, stop_det;

  always_ff @(posedge CK) begin
    if (SR) begin
      scl_sync_reg <= '1;
      sda_sync_reg <= '1;
      scl_prev_reg <= 1'b1;
      sda_prev_reg <= 1'b1;
    end else begin
      scl_sync_reg <= {scl_sync_reg[SYNC_STAGES-2:0], SCL_I};
      sda_sync_reg <= {sda_sync_reg[SYNC_STAGES-2:0], SDA_I};
      scl_prev_reg <= scl_s;
      sda_prev_reg <= sda_s;
    end
  end

  assign scl_s     = scl_sync_reg[SYNC_STAGES-1];
  assign sda_s     = sda_sync_reg[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_prev_reg;
  assign scl_fall  = ~scl_s & scl_prev_reg;
  // SDA may only move while SCL is low, so an SDA edge with SCL held high
  // on both samples is a START/STOP condition.
  assign start_det = scl_s & scl_prev_reg & sda_prev_reg & ~sda_s;
  assign stop_det  = scl_s & scl_prev_reg & ~sda_prev_reg & sda_s;

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;       // SCL rising edges seen in this byte
  logic [7:0]  shift_reg, shift_next;   // receive byte, or transmit byte (MSB on bus)
  logic        sda_oe_reg, sda_oe_next;
  logic [7:0]  addr_reg, addr_next;
  logic [7:0]  wdata_reg, wdata_next;
  logic        we_reg, we_next;
  logic        re_reg, re_next;
  logic        is_ptr_reg, is_ptr_next; // current WACK acknowledges the pointer byte
  logic        nack_reg, nack_next;     // controller response in RACK

  always_ff @(posedge CK) begin
    if (SR) begin
      state_reg  <= IDLE;
      cnt_reg    <= 4'd0;
      shift_reg  <= 8'h00;
      sda_oe_reg <= 1'b0;
      addr_reg   <= 8'h00;
      wdata_reg  <= 8'h00;
      we_reg     <= 1'b0;
      re_reg     <= 1'b0;
      is_ptr_reg <= 1'b0;
      nack_reg   <= 1'b1;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      shift_reg  <= shift_next;
      sda_oe_reg <= sda_oe_next;
      addr_reg   <= addr_next;
      wdata_reg  <= wdata_next;
      we_reg     <= we_next;
      re_reg     <= re_next;
      is_ptr_reg <= is_ptr_next;
      nack_reg   <= nack_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    shift_next  = shift_reg;
    sda_oe_next = sda_oe_reg;
    addr_next   = addr_reg;
    wdata_next  = wdata_reg;
    we_next     = 1'b0;
    re_next     = 1'b0;
    is_ptr_next = is_ptr_reg;
    nack_next   = nack_reg;

    if (start_det) begin
      // START or repeated START: the pointer is kept so a pointer write can
      // be followed by a read from that address.
      state_next  = ADDR;
      cnt_next    = 4'd0;
      sda_oe_next = 1'b0;
    end else if (stop_det) begin
      state_next  = IDLE;
      sda_oe_next = 1'b0;
    end else begin
      case (state_reg)
        ADDR, PTR, WDATA: begin
          if (scl_rise && cnt_reg < 4'd8) begin
            shift_next = {shift_reg[6:0], sda_s};
            cnt_next   = cnt_reg + 4'd1;
          end else if (scl_fall && cnt_reg == 4'd8) begin
            cnt_next = 4'd0;
            if (state_reg == ADDR) begin
              if (shift_reg[7:1] == DEV_ADDR) begin
                state_next  = ADDR_ACK;
                sda_oe_next = 1'b1;
              end else begin
                state_next  = IGNORE;
                sda_oe_next = 1'b0;
              end
            end else if (state_reg == PTR) begin
              addr_next   = shift_reg;
              is_ptr_next = 1'b1;
              state_next  = WACK;
              sda_oe_next = 1'b1;
            end else begin
              wdata_next  = shift_reg;
              we_next     = 1'b1;
              is_ptr_next = 1'b0;
              state_next  = WACK;
              sda_oe_next = 1'b1;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            sda_oe_next = 1'b0;
            cnt_next    = 4'd0;
            if (shift_reg[0]) begin
              state_next = RDATA;
              re_next    = 1'b1;
            end else begin
              state_next = PTR;
            end
          end
        end
        WACK: begin
          if (scl_fall) begin
            sda_oe_next = 1'b0;
            cnt_next    = 4'd0;
            state_next  = WDATA;
            if (!is_ptr_reg) addr_next = addr_reg + 8'd1;
          end
        end
        RDATA: begin
          if (re_reg) begin
            // Fabric data arrives the CK after the strobe; put the MSB out
            // while SCL is still low.
            shift_next  = REG_RDATA;
            sda_oe_next = ~REG_RDATA[7];
          end else if (scl_rise && cnt_reg < 4'd8) begin
            cnt_next = cnt_reg + 4'd1;
          end else if (scl_fall && cnt_reg == 4'd8) begin
            state_next  = RACK;
            sda_oe_next = 1'b0;
            cnt_next    = 4'd0;
          end else if (scl_fall && cnt_reg != 4'd0) begin
            shift_next  = {shift_reg[6:0], 1'b0};
            sda_oe_next = ~shift_reg[6];
          end
        end
        RACK: begin
          if (scl_rise) begin
            nack_next = sda_s;
          end else if (scl_fall) begin
            if (!nack_reg) begin
              state_next = RDATA;
              addr_next  = addr_reg + 8'd1;
              re_next    = 1'b1;
              cnt_next   = 4'd0;
            end else begin
              state_next = IGNORE;
            end
          end
        end
        default: sda_oe_next = 1'b0;  // IDLE, IGNORE
      endcase
    end
  end

  assign SDA_OE    = sda_oe_reg;
  assign REG_ADDR  = addr_reg;
  assign REG_WDATA = wdata_reg;
  assign REG_WE    = we_reg;
  assign REG_RE    = re_reg;
  assign BUSY      = (state_reg != IDLE);

endmodule
